// File: rtl/approx_softmax_pkg.sv
// Shared types and helpers for the approximate-softmax log-domain datapath.
// lod_pos is the leading-one detector used by the log2 front end.
package approx_softmax_pkg;

    localparam int LOG_FRAC_W = 8;
    localparam int LOD_W      = 64;
    localparam int LOD_POS_W  = 6;

    typedef struct packed {
        logic [LOD_POS_W-1:0]  k;
        logic [LOG_FRAC_W-1:0] frac;
    } log_t;

    // Index of the highest set bit; 0 for a zero operand (callers flag zero separately).
    function automatic logic [LOD_POS_W-1:0] lod_pos(input logic [LOD_W-1:0] v);
        logic [LOD_POS_W-1:0] pos;
        pos = {LOD_POS_W{1'b0}};
        for (int i = 0; i < LOD_W; i++) begin
            if (v[i]) begin
                pos = LOD_POS_W'(i);
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/approx_log2_norm.sv
// Normalizing barrel shifter: moves the leading one to the MSB and extracts
// the truncated fraction bits directly beneath it.
module approx_log2_norm #(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 8,
    parameter int K_W    = $clog2(DATA_W)
) (
    input  logic [DATA_W-1:0] data,
    input  logic [K_W-1:0]    k,
    output logic [FRAC_W-1:0] frac
);

    logic [K_W-1:0]    shamt_s;
    logic [DATA_W-1:0] norm_s;

    // Shift left so bit k lands in DATA_W-1; the cast drops the implicit leading one.
    always_comb begin
        shamt_s = K_W'(DATA_W - 1) - k;
        norm_s  = data << shamt_s;
        frac    = FRAC_W'(norm_s >> (DATA_W - 1 - FRAC_W));
    end

endmodule

// File: rtl/approx_log2_pipe.sv
// Two-stage Mitchell log2 approximator with valid/ready on both sides.
// S1 captures operand and leading-one position; S2 produces {k, frac}.
module approx_log2_pipe
    import approx_softmax_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int FRAC_W = LOG_FRAC_W,
    parameter int TAG_W  = 4,
    localparam int K_W   = $clog2(DATA_W)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [K_W+FRAC_W-1:0] out_log,
    output logic                  out_zero,
    output logic [TAG_W-1:0]      out_tag
);

    logic [K_W-1:0]        lod_k_s;
    logic                  in_xfer_s;
    logic                  out_xfer_s;
    logic                  s2_load_s;
    logic [FRAC_W-1:0]     frac_s;

    logic                  s1_valid_r;
    logic [DATA_W-1:0]     s1_data_r;
    logic [TAG_W-1:0]      s1_tag_r;
    logic [K_W-1:0]        s1_k_r;
    logic                  s1_zero_r;

    logic                  s2_valid_r;
    logic [K_W+FRAC_W-1:0] s2_log_r;
    logic                  s2_zero_r;
    logic [TAG_W-1:0]      s2_tag_r;

    generate
        if (DATA_W == 32) begin : g_lod32
            assign lod_k_s = K_W'(lod_pos({32'd0, in_data}));
        end else begin : g_lod64
            assign lod_k_s = K_W'(lod_pos(in_data));
        end
    endgenerate

    assign s2_load_s  = s1_valid_r && (!s2_valid_r || out_ready);
    assign in_ready   = !s1_valid_r || s2_load_s;
    assign in_xfer_s  = in_valid && in_ready;
    assign out_xfer_s = s2_valid_r && out_ready;

    approx_log2_norm #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .K_W    (K_W)
    ) u_norm (
        .data (s1_data_r),
        .k    (s1_k_r),
        .frac (frac_s)
    );

    // Stage 1: capture operand, tag, leading-one position and zero flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= {DATA_W{1'b0}};
            s1_tag_r   <= {TAG_W{1'b0}};
            s1_k_r     <= {K_W{1'b0}};
            s1_zero_r  <= 1'b0;
        end else if (in_xfer_s) begin
            s1_valid_r <= 1'b1;
            s1_data_r  <= in_data;
            s1_tag_r   <= in_tag;
            s1_k_r     <= lod_k_s;
            s1_zero_r  <= (in_data == {DATA_W{1'b0}});
        end else if (s2_load_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    // Stage 2: registered result; holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            s2_log_r   <= {(K_W+FRAC_W){1'b0}};
            s2_zero_r  <= 1'b0;
            s2_tag_r   <= {TAG_W{1'b0}};
        end else if (s2_load_s) begin
            s2_valid_r <= 1'b1;
            s2_log_r   <= s1_zero_r ? {(K_W+FRAC_W){1'b0}} : {s1_k_r, frac_s};
            s2_zero_r  <= s1_zero_r;
            s2_tag_r   <= s1_tag_r;
        end else if (out_xfer_s) begin
            s2_valid_r <= 1'b0;
        end
    end

    assign out_valid = s2_valid_r;
    assign out_log   = s2_log_r;
    assign out_zero  = s2_zero_r;
    assign out_tag   = s2_tag_r;

endmodule

// File: tb/tb_approx_log2_pipe.sv
// Self-checking bench for approx_log2_pipe: directed vectors, backpressure,
// reset flush, 64-bit spot checks and a randomized scoreboard run.
module tb_approx_log2_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, out_zero;
    logic [31:0] in_data;
    logic [3:0]  in_tag, out_tag;
    logic [12:0] out_log;

    logic        in_valid64, in_ready64, out_valid64, out_ready64, out_zero64;
    logic [63:0] in_data64;
    logic [3:0]  in_tag64, out_tag64;
    logic [13:0] out_log64;

    typedef struct {
        logic [12:0] lg;
        logic        z;
        logic [3:0]  tg;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t dq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   n_acc    = 0;
    logic lat_chk  = 1'b0;
    logic last_in_ready, last_out_valid;

    always #5 clk = ~clk;

    approx_log2_pipe #(.DATA_W(32), .FRAC_W(8), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_log(out_log), .out_zero(out_zero), .out_tag(out_tag)
    );

    approx_log2_pipe #(.DATA_W(64), .FRAC_W(8), .TAG_W(4)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid64), .in_ready(in_ready64),
        .in_data(in_data64), .in_tag(in_tag64), .out_valid(out_valid64),
        .out_ready(out_ready64), .out_log(out_log64), .out_zero(out_zero64), .out_tag(out_tag64)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: floor(log2(v)) and truncated fractional part of v/2^k - 1.
    function automatic logic [12:0] ref_log(input logic [31:0] v);
        int          k;
        logic [31:0] t;
        logic [63:0] f;
        if (v == 32'd0) return 13'd0;
        k = 0;
        t = v;
        while (t > 32'd1) begin
            t = t >> 1;
            k++;
        end
        f = ((64'(v) - (64'd1 << k)) << 8) >> k;
        return {k[4:0], f[7:0]};
    endfunction

    task automatic step(input logic iv, input logic [31:0] d, input logic [3:0] t, input logic ordy);
        exp_t e;
        exp_t c;
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        in_tag    = t;
        out_ready = ordy;
        #1;
        last_in_ready  = in_ready;
        last_out_valid = out_valid;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_val("spurious_out", 64'(out_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                check_val("out_log", 64'(out_log), 64'(e.lg));
                check_val("out_zero", 64'(out_zero), 64'(e.z));
                check_val("out_tag", 64'(out_tag), 64'(e.tg));
                if (lat_chk) check_val("latency", 64'(cyc - e.cyc), 64'd2);
                if (dq.size() != 0) begin
                    c = dq.pop_front();
                    check_val("const_log", 64'(out_log), 64'(c.lg));
                    check_val("const_zero", 64'(out_zero), 64'(c.z));
                end
            end
        end
        if (in_valid && in_ready) begin
            e.lg  = ref_log(in_data);
            e.z   = (in_data == 32'd0);
            e.tg  = in_tag;
            e.cyc = cyc;
            sb.push_back(e);
            n_acc++;
        end
        cyc++;
    endtask

    task automatic push_const(input logic [12:0] lg, input logic z);
        exp_t c;
        c.lg  = lg;
        c.z   = z;
        c.tg  = 4'd0;
        c.cyc = 0;
        dq.push_back(c);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1 << $urandom_range(0, 31);
            default: return $urandom >> $urandom_range(0, 31);
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_data = 32'd0; in_tag = 4'd0; out_ready = 1'b1;
        in_valid64 = 1'b0; in_data64 = 64'd0; in_tag64 = 4'd0; out_ready64 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_out_log", 64'(out_log), 64'd0);
        check_val("rst_out_zero", 64'(out_zero), 64'd0);
        check_val("rst_out_tag", 64'(out_tag), 64'd0);
        rst = 1'b0;
        #1;
        check_val("rst_in_ready", 64'(in_ready), 64'd1);

        // Directed vectors, back-to-back, latency checked.
        lat_chk = 1'b1;
        push_const(13'h000, 1'b0);
        push_const(13'h180, 1'b0);
        push_const(13'hC23, 1'b0);
        push_const(13'h1FFF, 1'b0);
        step(1'b1, 32'h0000_0001, 4'd1, 1'b1);
        step(1'b1, 32'h0000_0003, 4'd2, 1'b1);
        step(1'b1, 32'h0000_1234, 4'd3, 1'b1);
        step(1'b1, 32'hFFFF_FFFF, 4'd4, 1'b1);
        repeat (3) step(1'b0, 32'hDEAD_BEEF, 4'd0, 1'b1);
        check_val("directed_drained", 64'(dq.size()), 64'd0);

        // Zero operand followed by MSB-only operand.
        push_const(13'h000, 1'b1);
        push_const(13'h1F00, 1'b0);
        step(1'b1, 32'h0000_0000, 4'd5, 1'b1);
        step(1'b1, 32'h8000_0000, 4'd6, 1'b1);
        repeat (3) step(1'b0, 32'd0, 4'd0, 1'b1);
        check_val("zero_drained", 64'(dq.size()), 64'd0);

        // Backpressure: two absorbed, third refused, outputs hold, drain without bubbles.
        lat_chk = 1'b0;
        step(1'b1, 32'h0000_00F0, 4'd0, 1'b0);
        step(1'b1, 32'h0001_0000, 4'd1, 1'b0);
        step(1'b1, 32'h0000_0005, 4'd2, 1'b0);
        check_val("bp_in_ready", 64'(last_in_ready), 64'd0);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 32'h0000_0005, 4'd2, 1'b0);
            check_val("bp_hold_valid", 64'(out_valid), 64'd1);
            check_val("bp_hold_log", 64'(out_log), 64'(ref_log(32'h0000_00F0)));
            check_val("bp_hold_tag", 64'(out_tag), 64'd0);
            check_val("bp_in_ready_hold", 64'(last_in_ready), 64'd0);
        end
        step(1'b1, 32'h0000_0005, 4'd2, 1'b1);
        check_val("bp_accept_on_release", 64'(last_in_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step(1'b0, 32'd0, 4'd0, 1'b1);
            check_val("bp_no_bubble", 64'(last_out_valid), 64'd1);
        end
        step(1'b0, 32'd0, 4'd0, 1'b1);
        check_val("bp_drained", 64'(sb.size()), 64'd0);

        // Reset with two operands in flight.
        step(1'b1, 32'h0000_0777, 4'd7, 1'b0);
        step(1'b1, 32'h0ABC_0000, 4'd8, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_val("flush_out_valid", 64'(out_valid), 64'd0);
        check_val("flush_out_log", 64'(out_log), 64'd0);
        check_val("flush_out_zero", 64'(out_zero), 64'd0);
        check_val("flush_out_tag", 64'(out_tag), 64'd0);
        rst = 1'b0;
        sb.delete();
        dq.delete();
        #1;
        check_val("flush_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'd0, 4'd0, 1'b1);
            check_val("flush_no_stale", 64'(last_out_valid), 64'd0);
        end

        // 64-bit instance spot checks.
        @(negedge clk);
        in_valid64 = 1'b1;
        in_data64  = 64'h0000_0001_0000_0000;
        #1;
        check_val("w64_ready_a", 64'(in_ready64), 64'd1);
        @(negedge clk);
        in_data64 = 64'hC000_0000_0000_0000;
        #1;
        check_val("w64_ready_b", 64'(in_ready64), 64'd1);
        @(negedge clk);
        in_valid64 = 1'b0;
        #1;
        check_val("w64_valid_a", 64'(out_valid64), 64'd1);
        check_val("w64_log_a", 64'(out_log64), 64'h2000);
        @(negedge clk);
        #1;
        check_val("w64_valid_b", 64'(out_valid64), 64'd1);
        check_val("w64_log_b", 64'(out_log64), 64'h3F80);

        // Randomized traffic against the scoreboard.
        n_acc = 0;
        begin
            int start;
            start = cyc;
            while (n_acc < 10000 && (cyc - start) < 60000) begin
                step(($urandom_range(0, 3) != 0), rand_operand(), 4'($urandom),
                     ($urandom_range(0, 3) != 0));
            end
        end
        check_val("rand_accepted", 64'(n_acc), 64'd10000);
        for (int i = 0; i < 10; i++) step(1'b0, 32'd0, 4'd0, 1'b1);
        check_val("rand_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
